// File: rtl/conv_3x3_engine_pkg.sv
// Shared widths, types and requantisation helpers for the 3x3 convolution engine.
package conv_pkg;
    localparam int DATA_W    = 8;
    localparam int PROD_W    = 16;
    localparam int SHIFT_W   = 5;
    localparam int ACC_WIDTH = 32;

    typedef logic signed [DATA_W-1:0]  pix_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    // One guard bit so the rounding offset can never wrap the accumulator value
    typedef logic signed [ACC_WIDTH:0] ext_t;

    function automatic ext_t round_shift(acc_t x, logic [SHIFT_W-1:0] sh);
        ext_t v;
        v = ext_t'(x);
        if (sh != '0) begin
            v = v + (ext_t'(1) << (sh - 5'd1));
        end
        return v >>> sh;
    endfunction

    function automatic pix_t saturate8(ext_t x);
        pix_t r;
        if (x > ext_t'(127)) begin
            r = pix_t'(127);
        end else if (x < ext_t'(-128)) begin
            r = pix_t'(-128);
        end else begin
            r = pix_t'(x);
        end
        return r;
    endfunction
endpackage

// File: rtl/conv_3x3_engine_if.sv
// Input-beat and output-word handshake bundle of the 3x3 convolution engine.
interface conv_3x3_engine_if
    import conv_pkg::*;
#(
    parameter int NUM_PE = 8,
    parameter int LANES  = 8,
    parameter int ACC_W  = ACC_WIDTH
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic                                      last_channel;
    logic [2:0][2:0][LANES*DATA_W-1:0]         pixels;
    logic [NUM_PE-1:0][9*LANES*DATA_W-1:0]     weights;
    logic [NUM_PE-1:0][ACC_W-1:0]              biases;
    logic [SHIFT_W-1:0]                        quant_shift;
    logic                                      act_en;
    logic [NUM_PE*DATA_W-1:0]                  out_data;
    logic                                      out_valid;
    logic                                      out_ready;

    modport master (
        output in_valid, last_channel, pixels, weights, biases, quant_shift, act_en, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, last_channel, pixels, weights, biases, quant_shift, act_en, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/conv_3x3_engine_mac_pe.sv
// One output-channel PE: product stage, adder tree, bias/accumulate and int8 requantiser.
// Activation is leaky (slope 1/8) when CONV_LEAKY_RELU_EN is defined, plain ReLU otherwise.
module conv_mac_pe
    import conv_pkg::*;
#(
    parameter int LANES = 8,
    parameter int ACC_W = ACC_WIDTH
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2:0][2:0][LANES*DATA_W-1:0] pixels,
    input  logic [9*LANES*DATA_W-1:0]         weights,
    input  logic signed [ACC_W-1:0]           bias,
    input  logic                              s1_first,
    input  logic                              s2_valid,
    input  logic                              s2_first,
    input  logic [SHIFT_W-1:0]                s3_shift,
    input  logic                              s3_act,
    output pix_t                              q
);
    localparam int NPROD = 9 * LANES;

    logic [NPROD-1:0][PROD_W-1:0] prods;
    logic signed [ACC_W-1:0]      bias_reg;
    logic signed [ACC_W-1:0]      sum_reg;
    logic signed [ACC_W-1:0]      acc_reg;
    logic signed [ACC_W-1:0]      tree_sum;
    ext_t                         shifted;
    ext_t                         activated;

    // Product index gi = tap*LANES + lane, tap = 3*row + col
    for (genvar gi = 0; gi < NPROD; gi++) begin : g_mul
        pix_t  px;
        pix_t  wt;
        prod_t prod_reg;
        assign px = pix_t'(pixels[(gi/LANES)/3][(gi/LANES)%3][(gi%LANES)*DATA_W +: DATA_W]);
        assign wt = pix_t'(weights[gi*DATA_W +: DATA_W]);
        always_ff @(posedge clk) begin
            prod_reg <= prod_t'(px) * prod_t'(wt);
        end
        assign prods[gi] = prod_reg;
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < NPROD; i++) begin
            tree_sum = tree_sum + ACC_W'(signed'(prods[i]));
        end
    end

    // Bias rides alongside the products and is folded in with the tree sum of a first beat
    always_ff @(posedge clk) begin
        bias_reg <= bias;
        sum_reg  <= s1_first ? tree_sum + bias_reg : tree_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (s2_valid) begin
            acc_reg <= s2_first ? sum_reg : acc_reg + sum_reg;
        end
    end

    always_comb begin
        shifted   = round_shift(acc_t'(acc_reg), s3_shift);
        activated = shifted;
        if (s3_act && shifted[ACC_WIDTH]) begin
`ifdef CONV_LEAKY_RELU_EN
            activated = shifted >>> 3;
`else
            activated = '0;
`endif
        end
    end

    assign q = saturate8(activated);
endmodule

// File: rtl/conv_3x3_engine.sv
// 3x3 convolution engine: NUM_PE parallel PEs, credit-based intake and a registered output FIFO.
// Optional leaky activation is selected with CONV_LEAKY_RELU_EN (ReLU when undefined).
module conv_3x3_engine
    import conv_pkg::*;
#(
    parameter int NUM_PE     = 8,
    parameter int LANES      = 8,
    parameter int ACC_W      = ACC_WIDTH,
    parameter int FIFO_DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst,
    conv_3x3_engine_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = NUM_PE * DATA_W;

    logic               fire;
    logic               first_reg;
    logic               s1_valid_reg, s1_last_reg, s1_first_reg, s1_act_reg;
    logic               s2_valid_reg, s2_last_reg, s2_first_reg, s2_act_reg;
    logic               s3_valid_reg, s3_last_reg, s3_act_reg;
    logic [SHIFT_W-1:0] s1_shift_reg, s2_shift_reg, s3_shift_reg;
    logic [1:0]         inflight;

    logic [WORD_W-1:0]  pe_q;
    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [WORD_W-1:0]  out_data_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               push, pop;

    assign fire = bus.in_valid && bus.in_ready;

    // Every last_channel beat still in the pipe has a FIFO slot reserved for it
    assign inflight = 2'(s1_valid_reg && s1_last_reg) + 2'(s2_valid_reg && s2_last_reg)
                    + 2'(s3_valid_reg && s3_last_reg);
    assign bus.in_ready = (CNT_W'(FIFO_DEPTH) - count_reg) > CNT_W'(inflight);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_reg    <= 1'b1;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_act_reg   <= 1'b0;
            s1_shift_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_first_reg <= 1'b0;
            s2_act_reg   <= 1'b0;
            s2_shift_reg <= '0;
            s3_valid_reg <= 1'b0;
            s3_last_reg  <= 1'b0;
            s3_act_reg   <= 1'b0;
            s3_shift_reg <= '0;
        end else begin
            if (fire) begin
                first_reg <= bus.last_channel;
            end
            s1_valid_reg <= fire;
            s1_last_reg  <= fire && bus.last_channel;
            s1_first_reg <= first_reg;
            s1_act_reg   <= (fire && bus.last_channel) ? bus.act_en : 1'b0;
            s1_shift_reg <= (fire && bus.last_channel) ? bus.quant_shift : '0;
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            s2_first_reg <= s1_first_reg;
            s2_act_reg   <= s1_act_reg;
            s2_shift_reg <= s1_shift_reg;
            s3_valid_reg <= s2_valid_reg;
            s3_last_reg  <= s2_last_reg;
            s3_act_reg   <= s2_act_reg;
            s3_shift_reg <= s2_shift_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
        conv_mac_pe #(
            .LANES (LANES),
            .ACC_W (ACC_W)
        ) u_pe (
            .clk      (clk),
            .rst      (rst),
            .pixels   (bus.pixels),
            .weights  (bus.weights[gi]),
            .bias     (bus.biases[gi]),
            .s1_first (s1_first_reg),
            .s2_valid (s2_valid_reg),
            .s2_first (s2_first_reg),
            .s3_shift (s3_shift_reg),
            .s3_act   (s3_act_reg),
            .q        (pe_q[gi*DATA_W +: DATA_W])
        );
    end

    assign push = s3_valid_reg && s3_last_reg;
    assign pop  = (count_reg != '0) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= pe_q;
        end
    end

    // out_data_reg always mirrors the head entry so the output is a plain register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
            if (pop && count_reg >= CNT_W'(2)) begin
                out_data_reg <= mem[rd_ptr_reg + PTR_W'(1)];
            end else if (push && (count_reg == '0 || (pop && count_reg == CNT_W'(1)))) begin
                out_data_reg <= pe_q;
            end
        end
    end

    assign bus.out_valid = (count_reg != '0);
    assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_conv_3x3_engine.sv
// Scoreboard bench for conv_3x3_engine: arithmetic reference model, randomized groups and backpressure.
module tb_conv_3x3_engine;
    localparam int NUM_PE = 8;
    localparam int LANES  = 8;
    localparam int ACC_W  = 32;
    localparam int DEPTH  = 4;
    localparam int W      = NUM_PE * 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_3x3_engine_if #(.NUM_PE(NUM_PE), .LANES(LANES), .ACC_W(ACC_W)) bus ();

    conv_3x3_engine #(
        .NUM_PE(NUM_PE), .LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit rand_ready = 1'b0;

    byte        pix_b [3][3][LANES];
    byte        wt_b  [NUM_PE][9][LANES];
    int         bias_b[NUM_PE];
    int         acc_m [NUM_PE];
    bit         first_m = 1'b1;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic byte quant(int acc, int sh, bit act);
        longint v;
        v = longint'(acc);
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (act && v < 0) begin
`ifdef CONV_LEAKY_RELU_EN
            v = v >>> 3;
`else
            v = 0;
`endif
        end
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return byte'(v);
    endfunction

    task automatic model_accept(input bit last, input int sh, input bit act);
        logic [W-1:0] w;
        int s;
        w = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            s = 0;
            for (int t = 0; t < 9; t++)
                for (int k = 0; k < LANES; k++)
                    s += int'(pix_b[t/3][t%3][k]) * int'(wt_b[p][t][k]);
            acc_m[p] = first_m ? bias_b[p] + s : acc_m[p] + s;
        end
        first_m = last;
        if (last) begin
            for (int p = 0; p < NUM_PE; p++) w[p*8 +: 8] = quant(acc_m[p], sh, act);
            exp_q.push_back(w);
        end
    endtask

    task automatic fill(input int pv, input int wv, input int bv);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < LANES; k++) pix_b[r][c][k] = byte'(pv);
        for (int p = 0; p < NUM_PE; p++) begin
            bias_b[p] = bv;
            for (int t = 0; t < 9; t++)
                for (int k = 0; k < LANES; k++) wt_b[p][t][k] = byte'(wv);
        end
    endtask

    task automatic rand_beat();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < LANES; k++) pix_b[r][c][k] = byte'($urandom);
        for (int p = 0; p < NUM_PE; p++) begin
            bias_b[p] = int'($urandom_range(0, 200000)) - 100000;
            for (int t = 0; t < 9; t++)
                for (int k = 0; k < LANES; k++) wt_b[p][t][k] = byte'($urandom);
        end
    endtask

    task automatic drive(input bit last, input int sh, input bit act);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < LANES; k++) bus.pixels[r][c][k*8 +: 8] = pix_b[r][c][k];
        for (int p = 0; p < NUM_PE; p++) begin
            bus.biases[p] = bias_b[p];
            for (int t = 0; t < 9; t++)
                for (int k = 0; k < LANES; k++) bus.weights[p][(t*LANES+k)*8 +: 8] = wt_b[p][t][k];
        end
        bus.last_channel = last;
        bus.quant_shift  = 5'(sh);
        bus.act_en       = act;
        bus.in_valid     = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input bit last, input int sh, input bit act);
        int waited;
        waited = 0;
        drive(last, sh, act);
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("in_ready wait", W'(waited < 200), W'(1));
        if (waited < 200) model_accept(last, sh, act);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain empty", W'(exp_q.size()), W'(0));
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        if (rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected output: got %h expected none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                $display("out %0d data=%h exp=%h", pops, bus.out_data, e);
                chk("out_data", bus.out_data, e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int sh, nb, acc_cnt, p0;
        bit act;
        bus.in_valid = 1'b0; bus.last_channel = 1'b0; bus.pixels = '0; bus.weights = '0;
        bus.biases = '0; bus.quant_shift = '0; bus.act_en = 1'b0; bus.out_ready = 1'b1;
        #1;
        chk("reset in_ready", W'(bus.in_ready), W'(1));
        chk("reset out_valid", W'(bus.out_valid), W'(0));
        chk("reset out_data", bus.out_data, W'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single group: sum 72 + bias 5, output visible three edges after the accept edge
        fill(1, 1, 5);
        send(1'b1, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("latency early out_valid", W'(bus.out_valid), W'(0));
        @(posedge clk); #1;
        chk("latency out_valid", W'(bus.out_valid), W'(1));
        drain();

        // Two groups; bias offered on the second beat must be ignored
        fill(2, 1, -10);
        send(1'b0, 0, 1'b0);
        fill(1, 1, 12345);
        send(1'b1, 2, 1'b0);
        drain();

        // Saturation and activation around acc = -400
        fill(0, 0, -400);
        send(1'b1, 0, 1'b1);
        send(1'b1, 0, 1'b0);
        drain();

        // Backpressure: FIFO fills to DEPTH, then drains in order
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rand_beat();
            sh = $urandom_range(4, 14);
            act = 1'($urandom);
            drive(1'b1, sh, act);
            if (bus.in_ready === 1'b1) begin
                model_accept(1'b1, sh, act);
                acc_cnt++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp accepted", W'(acc_cnt), W'(DEPTH));
        chk("bp in_ready low", W'(bus.in_ready), W'(0));
        chk("bp out_valid", W'(bus.out_valid), W'(1));
        for (int i = 0; i < 3; i++) begin
            chk("bp hold data", bus.out_data, exp_q[0]);
            @(posedge clk); #1;
        end
        p0 = pops;
        bus.out_ready = 1'b1;
        drain();
        chk("bp pop count", W'(pops - p0), W'(DEPTH));

        // Reset in the middle of a group
        rand_beat();
        send(1'b0, 0, 1'b0);
        #2 rst = 1'b0;
        exp_q.delete();
        first_m = 1'b1;
        #1;
        chk("mid reset in_ready", W'(bus.in_ready), W'(1));
        chk("mid reset out_valid", W'(bus.out_valid), W'(0));
        chk("mid reset out_data", bus.out_data, W'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        fill(1, 1, 3);
        send(1'b1, 0, 1'b0);
        drain();

        // Randomized groups with random consumer stalls
        rand_ready = 1'b1;
        for (int g = 0; g < 30; g++) begin
            nb  = $urandom_range(1, 3);
            sh  = $urandom_range(0, 14);
            act = 1'($urandom);
            for (int b = 0; b < nb; b++) begin
                rand_beat();
                send(b == nb - 1, sh, act);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        drain();
        repeat (5) @(posedge clk);
        #1 chk("final out_valid", W'(bus.out_valid), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_3x3_engine.md
# conv_3x3_engine

Parametrised successor to the fixed 8-PE 3x3 convolution array. It takes one 3x3 window of LANES signed int8 input channels per beat and NUM_PE weight sets, and accumulates across input-channel groups with bias. It then requantises, activates and saturates each PE result to int8, and presents the full output-channel word through a valid/ready FIFO with backpressure. It sits between the line-buffer/window generator and the output writer of the convolution datapath.

## Interface
- NUM_PE, 8, output channels computed in parallel (one PE each)
- LANES, 8, int8 input channels per pixel word
- ACC_W, 32, accumulator and bias width
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat
- last_channel  in  1  beat is the final input-channel group of the output pixel
- pixels  in  [3][3][LANES*8]  signed int8 window, lane k at bits [8k+7:8k]
- weights  in  [NUM_PE][9*LANES*8]  per-PE weights, tap t=3r+c, lane k at bits [(t*LANES+k)*8+7 : ...]
- biases  in  [NUM_PE][ACC_W]  signed per-PE bias
- quant_shift  in  5  arithmetic right shift for requantisation
- act_en  in  1  apply activation
- out_data  out  [NUM_PE*8]  signed int8 results, PE p at bits [8p+7:8p]
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data

## Operation
- Beat accepted when in_valid && in_ready. quant_shift/act_en are sampled only on accepted last_channel beats and travel with that beat.
- Stage 1: 9*LANES signed 8x8 products per PE, registered (16-bit each).
- Stage 2: adder tree per PE, sign-extended to ACC_W, registered.
- Stage 3: accumulator per PE. On the first beat of a group (after reset or after a last_channel beat): acc = bias + sum. Otherwise acc = acc + sum. Wraps modulo 2^ACC_W with no saturation. Biases are sampled on the first beat.
- Stage 4 (last_channel beats only):
  - If quant_shift > 0, add 1<<(quant_shift-1) (round half up), then arithmetic shift right by quant_shift.
  - Activation per Configuration.
  - Saturate to [-128, 127] and write into the FIFO.
- Non-last beats produce no output.
- Credit rule: in_ready = (FIFO free entries) > (last_channel beats in stages 1-3). No overflow is possible, and in_ready never depends combinationally on out_ready.
- FIFO: out_valid = !empty. Pop on out_valid && out_ready. A simultaneous push and pop when full is impossible by the credit rule. A simultaneous push and pop at any other count keeps the count unchanged.
- Reset (async, any time) behaviour:
  - Clears all stage valids, accumulators, the first-beat flag (set to 1), the FIFO pointers and the count.
  - Reset values: in_ready=1, out_valid=0, out_data=0.
  - A partially accumulated group is discarded.

## Timing
- Latency: last_channel beat accepted at cycle N gives a FIFO write at the N+4 edge and out_valid high in cycle N+4 if the FIFO was empty.
- Throughput: one beat per cycle while in_ready=1. The pipeline itself never stalls. Backpressure acts only through in_ready.
- out_data is registered (FIFO read data) and holds stable while out_valid && !out_ready.
- in_ready can deassert with up to 3 last_channel beats in flight. It reasserts the cycle after a pop frees enough credit.

## Configuration
- CONV_LEAKY_RELU_EN defined:
  - act_en=1 with negative x gives x >>> 3 (slope 1/8, arithmetic, floor).
  - act_en=1 with non-negative x passes x unchanged.
- CONV_LEAKY_RELU_EN undefined:
  - act_en=1 with negative x gives 0 (plain ReLU).
- Either way, act_en=0 passes the value unchanged. Activation is applied after the shift and before saturation.

## Structure
- Package conv_pkg: DATA_W=8, PROD_W=16, SHIFT_W=5, typedefs pix_t (signed 8-bit), acc_t (signed ACC_W), and the saturate/round helper functions.
- Sub-module conv_mac_pe: one PE, covering stages 1-3 plus the stage-4 quantiser. It is instantiated NUM_PE times by generate. The credit counter and output FIFO stay in the top level.

## Test plan
- Single group: all pixels=1, all weights=1 (LANES=8), bias=5, shift=0, act_en=0, last_channel=1. Each PE gives sum 72, acc 77, out_data byte 77, out_valid 4 cycles after accept.
- Two groups: beat 1 all 2x1, beat 2 (last) all 1x1, bias=-10, shift=2. acc=144+72-10=206, output (206+2)>>>2=52.
- Saturation and activation: acc=-400, shift=0, act_en=1:
  - With CONV_LEAKY_RELU_EN: -400>>>3=-50, out -50.
  - Without: out 0.
  - act_en=0: out -128.
- Backpressure: out_ready=0 with continuous last_channel beats. Exactly FIFO_DEPTH results are held and in_ready drops. Raising out_ready drains results in order with none lost or duplicated.
- Reset mid-group: async rst low after a non-last beat. Outputs are at reset values immediately. After release, the next group's result contains only post-reset beats plus bias.
